// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, funct3 function codes and the decoded bundle.
// Consumed by the decoder and by the ALU datapath.
package alu_pkg;

    localparam int INSTR_W = 32;
    localparam int FUNC_W  = 3;
    localparam int REG_W   = 4;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [FUNC_W-1:0] FUNC_ADD  = 3'b000;
    localparam logic [FUNC_W-1:0] FUNC_SLL  = 3'b001;
    localparam logic [FUNC_W-1:0] FUNC_SLT  = 3'b010;
    localparam logic [FUNC_W-1:0] FUNC_SLTU = 3'b011;
    localparam logic [FUNC_W-1:0] FUNC_XOR  = 3'b100;
    localparam logic [FUNC_W-1:0] FUNC_SRL  = 3'b101;
    localparam logic [FUNC_W-1:0] FUNC_OR   = 3'b110;
    localparam logic [FUNC_W-1:0] FUNC_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic              f7_bit;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic              use_imm;
        logic              illegal;
    } dec_t;

    // RV32E only has x0-x15
    function automatic logic reg_ok(input logic [4:0] r);
        return !r[4];
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational field extraction and legality check for ALU instructions.
// LUI decoding is enabled by defining ALU_DEC_LUI_EN.
module alu_decode_comb
    import alu_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [INSTR_W-1:0] instr_i,
    output dec_t               dec_o,
    output logic [SIZE-1:0]    imm_o
);

    logic [6:0]        opc;
    logic [FUNC_W-1:0] funct3;
    logic [6:0]        funct7;
    logic [4:0]        rs1f;
    logic [4:0]        rs2f;
    logic [4:0]        rdf;
    logic [31:0]       imm32;
    logic              legal;
    logic              shamt_ok;

    assign opc    = instr_i[6:0];
    assign rdf    = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1f   = instr_i[19:15];
    assign rs2f   = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    always_comb begin
        dec_o    = '0;
        imm32    = '0;
        legal    = 1'b0;
        shamt_ok = 1'b1;
        if (funct3 == FUNC_SLL) begin
            shamt_ok = (funct7 == F7_BASE);
        end else if (funct3 == FUNC_SRL) begin
            shamt_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end
        case (opc)
            OPC_OP: begin
                legal = ((funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) &&
                          ((funct3 == FUNC_ADD) || (funct3 == FUNC_SRL))))
                        && reg_ok(rs1f) && reg_ok(rs2f) && reg_ok(rdf);
                dec_o.func    = funct3;
                dec_o.f7_bit  = instr_i[30];
                dec_o.rs1     = rs1f[3:0];
                dec_o.rs2     = rs2f[3:0];
                dec_o.rd      = rdf[3:0];
                dec_o.use_imm = 1'b0;
            end
            OPC_OPIMM: begin
                legal = shamt_ok && reg_ok(rs1f) && reg_ok(rdf);
                dec_o.func    = funct3;
                dec_o.f7_bit  = (funct3 == FUNC_SRL) && instr_i[30];
                dec_o.rs1     = rs1f[3:0];
                dec_o.rd      = rdf[3:0];
                dec_o.use_imm = 1'b1;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
`ifdef ALU_DEC_LUI_EN
            OPC_LUI: begin
                legal = reg_ok(rdf);
                dec_o.func    = FUNC_ADD;
                dec_o.rd      = rdf[3:0];
                dec_o.use_imm = 1'b1;
                imm32 = {instr_i[31:12], 12'b0};
            end
`endif
            default: begin
                legal = 1'b0;
            end
        endcase
        // An illegal bundle carries no operation, only the flag
        if (!legal) begin
            dec_o = '0;
            imm32 = '0;
        end
        dec_o.illegal = !legal;
    end

    assign imm_o = SIZE'($signed(imm32));

endmodule

// File: rtl/alu_decoder.sv
// ALU instruction decoder: one-entry valid/ready output register plus a
// saturating illegal-instruction counter. LUI support via ALU_DEC_LUI_EN.
module alu_decoder
    import alu_pkg::*;
#(
    parameter int SIZE      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FUNC_W-1:0]    out_func_type,
    output logic                 out_f7_bit,
    output logic [REG_W-1:0]     out_rs1,
    output logic [REG_W-1:0]     out_rs2,
    output logic [REG_W-1:0]     out_rd,
    output logic [SIZE-1:0]      out_imm,
    output logic                 out_use_imm,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    dec_t                 dec;
    dec_t                 out_q;
    dec_t                 out_d;
    logic [SIZE-1:0]      imm;
    logic [SIZE-1:0]      imm_q;
    logic [SIZE-1:0]      imm_d;
    logic                 valid_q;
    logic                 valid_d;
    logic [ILL_CNT_W-1:0] ill_q;
    logic [ILL_CNT_W-1:0] ill_d;
    logic                 accept;

    alu_decode_comb #(
        .SIZE(SIZE)
    ) u_comb (
        .instr_i(in_instr),
        .dec_o  (dec),
        .imm_o  (imm)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_d   = out_q;
        imm_d   = imm_q;
        valid_d = valid_q;
        ill_d   = ill_q;
        if (accept) begin
            out_d   = dec;
            imm_d   = imm;
            valid_d = 1'b1;
            if (dec.illegal && (ill_q != '1)) begin
                ill_d = ill_q + ILL_CNT_W'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            ill_q   <= '0;
        end else begin
            out_q   <= out_d;
            imm_q   <= imm_d;
            valid_q <= valid_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_func_type = out_q.func;
    assign out_f7_bit    = out_q.f7_bit;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_rd        = out_q.rd;
    assign out_imm       = imm_q;
    assign out_use_imm   = out_q.use_imm;
    assign out_illegal   = out_q.illegal;
    assign ill_count     = ill_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: vector table, scoreboard,
// backpressure and mid-hold reset sequences.
module tb_alu_decoder;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fn;
        logic        f7;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [31:0] imm;
        logic        ui;
        logic        ill;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_func_type;
    logic        out_f7_bit;
    logic [3:0]  out_rs1;
    logic [3:0]  out_rs2;
    logic [3:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic        out_illegal;
    logic [7:0]  ill_count;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    logic [7:0] ill_m = 8'd0;
    vec_t tbl[14];

    alu_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_func_type(out_func_type),
        .out_f7_bit   (out_f7_bit),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_imm      (out_imm),
        .out_use_imm  (out_use_imm),
        .out_illegal  (out_illegal),
        .ill_count    (ill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [2:0] fn,
                                input logic f7, input logic [3:0] r1,
                                input logic [3:0] r2, input logic [3:0] rd,
                                input logic [31:0] imm, input logic ui,
                                input logic ill);
        vec_t v;
        v.instr = i; v.fn = fn; v.f7 = f7; v.rs1 = r1; v.rs2 = r2;
        v.rd = rd; v.imm = imm; v.ui = ui; v.ill = ill;
        return v;
    endfunction

    function automatic vec_t bad(input logic [31:0] i);
        return mk(i, 3'd0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b1);
    endfunction

    // Scoreboard: compare each bundle as it is handed over
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("illegal", 32'(out_illegal), 32'(e.ill));
                chk("func", 32'(out_func_type), 32'(e.fn));
                chk("f7", 32'(out_f7_bit), 32'(e.f7));
                chk("rd", 32'(out_rd), 32'(e.rd));
                chk("use_imm", 32'(out_use_imm), 32'(e.ui));
                chk("imm", out_imm, e.imm);
                if (!e.ill) begin
                    chk("rs1", 32'(out_rs1), 32'(e.rs1));
                    chk("rs2", 32'(out_rs2), 32'(e.rs2));
                end
            end
        end
    end

    task automatic send(input vec_t e);
        int c;
        in_valid = 1'b1;
        in_instr = e.instr;
        c = 0;
        @(negedge clk);
        while (!in_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'd1, 32'd0);
        end else begin
            sb.push_back(e);
            if (e.ill && ill_m != 8'hFF) ill_m++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t a;
        vec_t b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        out_ready = 1'b1;

        tbl[0]  = mk(32'h002081B3, 3'd0, 1'b0, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0, 1'b0);
        tbl[1]  = mk(32'h40335293, 3'd5, 1'b1, 4'd6, 4'd0, 4'd5, 32'h403, 1'b1, 1'b0);
        tbl[2]  = mk(32'hFFF00093, 3'd0, 1'b0, 4'd0, 4'd0, 4'd1, 32'hFFFFFFFF, 1'b1, 1'b0);
        tbl[3]  = bad(32'h00208833);
        tbl[4]  = mk(32'h402081B3, 3'd0, 1'b1, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0, 1'b0);
        tbl[5]  = bad(32'h40109093);
        tbl[6]  = bad(32'h4020F1B3);
        tbl[7]  = mk(32'h7FF26213, 3'd6, 1'b0, 4'd4, 4'd0, 4'd4, 32'h7FF, 1'b1, 1'b0);
        tbl[8]  = mk(32'h01F3D393, 3'd5, 1'b0, 4'd7, 4'd0, 4'd7, 32'h1F, 1'b1, 1'b0);
        tbl[9]  = bad(32'h00188093);
        tbl[10] = bad(32'h014081B3);
        tbl[11] = bad(32'h00000000);
`ifdef ALU_DEC_LUI_EN
        tbl[12] = mk(32'h12345137, 3'd0, 1'b0, 4'd0, 4'd0, 4'd2, 32'h12345000, 1'b1, 1'b0);
`else
        tbl[12] = bad(32'h12345137);
`endif
        tbl[13] = mk(32'h00F0F093, 3'd7, 1'b0, 4'd1, 4'd0, 4'd1, 32'hF, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ill_count", 32'(ill_count), 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) send(tbl[i]);
        chk("ill_count_table", 32'(ill_count), 32'(ill_m));
        drain();
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 260; i++) send(bad(32'hFFFFFFFF));
        chk("ill_count_sat", 32'(ill_count), 32'(ill_m));
        chk("ill_count_255", 32'(ill_count), 32'd255);
        drain();

        // Backpressure: first bundle held, second waits for out_ready
        a = tbl[0];
        b = tbl[1];
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = a.instr;
        @(negedge clk);
        chk("bp_accept_a", 32'(in_ready), 32'd1);
        sb.push_back(a);
        @(posedge clk);
        #1;
        in_instr = b.instr;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_rd", 32'(out_rd), 32'd3);
            chk("bp_hold_rs2", 32'(out_rs2), 32'd2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_b", 32'(in_ready), 32'd1);
        sb.push_back(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        chk("bp_b_rd", 32'(out_rd), 32'd5);
        chk("bp_b_imm", out_imm, 32'h403);
        drain();

        // Reset while a bundle is held discards it immediately
        out_ready = 1'b0;
        send(tbl[3]);
        @(posedge clk);
        #2;
        chk("hold_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_rd", 32'(out_illegal), 32'd0);
        chk("mid_rst_ill", 32'(ill_count), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        sb.delete();
        ill_m = 8'd0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(tbl[7]);
        drain();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
